// File: rtl/param_tile_stream_source.sv
// Streams a tiled parameter tensor from a fixed-latency ROM as valid/ready
// beats, prefetching under a credit limit that covers the read latency.
module param_tile_stream_source #(
    parameter int DATA_WIDTH        = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 4,
    parameter int PARALLELISM_DIM_0 = 4,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int MEM_LATENCY       = 2,
    parameter int FIFO_DEPTH        = MEM_LATENCY + 2,
    parameter int REPEAT_WIDTH      = 8,
    localparam int BEAT      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    localparam int BLK0      = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    localparam int BLK1      = TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1,
    localparam int OUT_DEPTH = BLK0 * BLK1,
    localparam int AWIDTH    = $clog2(OUT_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [REPEAT_WIDTH-1:0]    repeat_count,
    output logic                       busy,
    output logic [AWIDTH-1:0]          mem_addr,
    output logic                       mem_ce,
    input  logic [DATA_WIDTH*BEAT-1:0] mem_q,
    output logic [DATA_WIDTH-1:0]      data_out [BEAT],
    output logic                       data_out_valid,
    input  logic                       data_out_ready,
    output logic                       data_out_last_row,
    output logic                       data_out_last,
    output logic                       pass_done
);

    localparam int WORD_W = DATA_WIDTH * BEAT;
    localparam int B0W    = (BLK0 > 1) ? $clog2(BLK0) : 1;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int IW     = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [AWIDTH-1:0]       addr_q, addr_d;
    logic [B0W-1:0]          b0_q, b0_d;
    logic [REPEAT_WIDTH-1:0] reps_q, reps_d;
    logic                    cont_q, cont_d;
    logic [MEM_LATENCY-1:0]  tag_vld_q, tag_vld_d;
    logic [MEM_LATENCY-1:0]  tag_row_q, tag_row_d;
    logic [MEM_LATENCY-1:0]  tag_last_q, tag_last_d;
    logic [IW-1:0]           infl_q, infl_d;
    logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0]       fifo_data_q [FIFO_DEPTH];
    logic [WORD_W-1:0]       fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_row_q, fifo_row_d;
    logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;

    logic fifo_empty;
    logic pop;
    logic push;
    logic credit;
    logic issue;
    logic at_wrap;
    logic final_rd;
    logic drain_done;
    logic [WORD_W-1:0] head;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = !fifo_empty && data_out_ready;
    assign push       = tag_vld_q[MEM_LATENCY-1];
    assign credit     = (int'(fifo_cnt_q) + int'(infl_q)) < FIFO_DEPTH;
    assign issue      = (state_q == ISSUE) && credit;
    assign at_wrap    = (addr_q == AWIDTH'(OUT_DEPTH - 1));
    assign final_rd   = issue && at_wrap && !cont_q
                        && (reps_q == REPEAT_WIDTH'(1));

    // Run ends on the cycle the last buffered beat leaves.
    assign drain_done = (state_q == DRAIN) && (infl_q == '0)
                        && (fifo_empty || ((fifo_cnt_q == CW'(1)) && pop));

    assign busy              = (state_q != IDLE) && !drain_done;
    assign mem_ce            = issue;
    assign mem_addr          = addr_q;
    assign data_out_valid    = !fifo_empty;
    assign data_out_last_row = fifo_row_q[rd_ptr_q];
    assign data_out_last     = fifo_last_q[rd_ptr_q];
    assign pass_done         = pop && fifo_last_q[rd_ptr_q];
    assign head              = fifo_data_q[rd_ptr_q];

    always_comb begin
        for (int j = 0; j < BEAT; j++) begin
            data_out[j] = head[DATA_WIDTH*j +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        b0_d    = b0_q;
        reps_d  = reps_q;
        cont_d  = cont_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    reps_d  = repeat_count;
                    cont_d  = (repeat_count == '0);
                    addr_d  = '0;
                    b0_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    if (at_wrap) begin
                        addr_d = '0;
                        if (!cont_q) begin
                            reps_d = reps_q - 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (b0_q == B0W'(BLK0 - 1)) begin
                        b0_d = '0;
                    end else begin
                        b0_d = b0_q + 1'b1;
                    end
                    if (final_rd) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags ride alongside the ROM pipeline so mem_q is captured on arrival.
    always_comb begin
        tag_vld_d     = '0;
        tag_row_d     = '0;
        tag_last_d    = '0;
        tag_vld_d[0]  = issue;
        tag_row_d[0]  = issue && (b0_q == B0W'(BLK0 - 1));
        tag_last_d[0] = issue && at_wrap;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_row_d[i]  = tag_row_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end
    end

    always_comb begin
        infl_d = infl_q;
        if (issue && !push) begin
            infl_d = infl_q + 1'b1;
        end else if (!issue && push) begin
            infl_d = infl_q - 1'b1;
        end
    end

    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_data_d = fifo_data_q;
        fifo_row_d  = fifo_row_q;
        fifo_last_d = fifo_last_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_q;
            fifo_row_d[wr_ptr_q]  = tag_row_q[MEM_LATENCY-1];
            fifo_last_d[wr_ptr_q] = tag_last_q[MEM_LATENCY-1];
            if (wr_ptr_q == PW'(FIFO_DEPTH - 1)) begin
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
        if (pop) begin
            if (rd_ptr_q == PW'(FIFO_DEPTH - 1)) begin
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            b0_q        <= '0;
            reps_q      <= '0;
            cont_q      <= 1'b0;
            tag_vld_q   <= '0;
            tag_row_q   <= '0;
            tag_last_q  <= '0;
            infl_q      <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_row_q  <= '0;
            fifo_last_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            b0_q        <= b0_d;
            reps_q      <= reps_d;
            cont_q      <= cont_d;
            tag_vld_q   <= tag_vld_d;
            tag_row_q   <= tag_row_d;
            tag_last_q  <= tag_last_d;
            infl_q      <= infl_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_row_q  <= fifo_row_d;
            fifo_last_q <= fifo_last_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: tb/tb_param_tile_stream_source.sv
// Bench for param_tile_stream_source: ROM model, ready patterns and a
// beat-sequence model checked against the DUT every cycle.
module tb_param_tile_stream_source;

    localparam int DW    = 16;
    localparam int T0    = 8;
    localparam int T1    = 2;
    localparam int P0    = 2;
    localparam int P1    = 1;
    localparam int ML    = 2;
    localparam int FD    = ML + 2;
    localparam int RW    = 8;
    localparam int BEAT  = P0 * P1;
    localparam int BLK0  = T0 / P0;
    localparam int DEPTH = BLK0 * (T1 / P1);
    localparam int AW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [RW-1:0]     repeat_count = '0;
    logic              busy;
    logic [AW-1:0]     mem_addr;
    logic              mem_ce;
    logic [DW*BEAT-1:0] mem_q;
    logic [DW-1:0]     data_out [BEAT];
    logic              data_out_valid;
    logic              data_out_ready = 1'b1;
    logic              data_out_last_row;
    logic              data_out_last;
    logic              pass_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_tile_stream_source #(
        .DATA_WIDTH(DW),
        .TENSOR_SIZE_DIM_0(T0),
        .TENSOR_SIZE_DIM_1(T1),
        .PARALLELISM_DIM_0(P0),
        .PARALLELISM_DIM_1(P1),
        .MEM_LATENCY(ML),
        .FIFO_DEPTH(FD),
        .REPEAT_WIDTH(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .repeat_count(repeat_count),
        .busy(busy),
        .mem_addr(mem_addr),
        .mem_ce(mem_ce),
        .mem_q(mem_q),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .data_out_last_row(data_out_last_row),
        .data_out_last(data_out_last),
        .pass_done(pass_done)
    );

    // Enable-independent 2-cycle ROM: word i = {2i+1, 2i}
    logic [AW-1:0] ra1;
    always @(posedge clk) begin
        ra1   <= mem_addr;
        mem_q <= {DW'(2 * ra1 + 1), DW'(2 * ra1)};
    end

    int rmode = 0;
    int rcyc = 0;
    always @(posedge clk) begin
        #1;
        rcyc++;
        if (rmode == 0) data_out_ready = 1'b1;
        else data_out_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit run_on = 0;
    int n_total = 0;
    int k = 0;
    int issued = 0;
    int accepted = 0;
    int iss_idx = 0;
    int lat = 0;
    int first_lat = -1;
    int pass_cnt = 0;
    int addr0_cnt = 0;
    int ncyc = 0;
    int first_x = -1;
    int last_x = -1;
    bit prev_stall = 0;
    int prev_d0 = 0;
    int prev_d1 = 0;

    always @(negedge clk) begin
        bit xfer;
        bit was_on;
        int a;
        ncyc++;
        if (rst) begin
            run_on = 0;
            k = 0;
            issued = 0;
            accepted = 0;
            iss_idx = 0;
            prev_stall = 0;
        end else begin
            was_on = run_on;
            xfer = data_out_valid && data_out_ready;
            a = k % DEPTH;
            chk("busy", int'(busy),
                int'(run_on && !(xfer && n_total != 0 && k + 1 == n_total)));
            chk("pass_done", int'(pass_done), int'(xfer && a == DEPTH - 1));
            if (!run_on) begin
                chk("idle_valid", int'(data_out_valid), 0);
                chk("idle_ce", int'(mem_ce), 0);
            end
            if (prev_stall) begin
                chk("stall_valid", int'(data_out_valid), 1);
                chk("stall_d0", int'(data_out[0]), prev_d0);
                chk("stall_d1", int'(data_out[1]), prev_d1);
            end
            if (mem_ce) begin
                chk("credit", int'(issued - accepted < FD), 1);
                chk("mem_addr", int'(mem_addr), iss_idx % DEPTH);
                if (mem_addr == '0) addr0_cnt++;
                issued++;
                iss_idx++;
            end
            if (run_on) lat++;
            if (run_on && data_out_valid && first_lat < 0) first_lat = lat;
            if (xfer) begin
                chk("d0", int'(data_out[0]), 2 * a);
                chk("d1", int'(data_out[1]), 2 * a + 1);
                chk("last_row", int'(data_out_last_row), int'(a % BLK0 == BLK0 - 1));
                chk("last", int'(data_out_last), int'(a == DEPTH - 1));
                if (a == DEPTH - 1) pass_cnt++;
                if (first_x < 0) first_x = ncyc;
                last_x = ncyc;
                k++;
                accepted++;
                if (n_total != 0 && k == n_total) run_on = 0;
            end
            prev_stall = data_out_valid && !data_out_ready;
            prev_d0 = int'(data_out[0]);
            prev_d1 = int'(data_out[1]);
            if (start && !was_on) begin
                run_on = 1;
                n_total = int'(repeat_count) * DEPTH;
                k = 0;
                lat = 0;
                first_lat = -1;
                pass_cnt = 0;
                addr0_cnt = 0;
                iss_idx = 0;
                issued = 0;
                accepted = 0;
                first_x = -1;
                last_x = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int rc);
        start = 1'b1;
        repeat_count = RW'(rc);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (run_on && n < budget) begin
            tick();
            n++;
        end
        chk("run_done", int'(run_on), 0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ce", int'(mem_ce), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_valid", int'(data_out_valid), 0);
        chk("rst_pass", int'(pass_done), 0);
        tick();

        // Single pass, ready held high
        do_start(1);
        wait_done(60);
        chk("t1_beats", k, 8);
        chk("t1_latency", first_lat, 4);
        chk("t1_pass", pass_cnt, 1);
        chk("t1_span", last_x - first_x, 7);
        repeat (3) tick();

        // Backpressure 1,0,0,1
        rmode = 1;
        do_start(1);
        wait_done(100);
        rmode = 0;
        chk("t2_beats", k, 8);
        chk("t2_pass", pass_cnt, 1);
        repeat (3) tick();

        // Three passes
        do_start(3);
        wait_done(150);
        chk("t3_beats", k, 24);
        chk("t3_pass", pass_cnt, 3);
        chk("t3_addr0", addr0_cnt, 3);
        repeat (3) tick();

        // Start while busy is ignored
        do_start(1);
        repeat (3) tick();
        start = 1'b1;
        repeat_count = RW'(5);
        tick();
        start = 1'b0;
        wait_done(60);
        repeat (10) tick();
        chk("t5_beats", k, 8);
        chk("t5_pass", pass_cnt, 1);

        // Reset mid-run after beat 3
        do_start(1);
        begin
            int n = 0;
            while (k < 4 && n < 50) begin
                tick();
                n++;
            end
        end
        chk("t6_reached", int'(k >= 4), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", int'(data_out_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ce", int'(mem_ce), 0);
        repeat (4) tick();
        do_start(1);
        wait_done(60);
        chk("t6_beats", k, 8);
        chk("t6_latency", first_lat, 4);
        repeat (3) tick();

        // Continuous mode
        do_start(0);
        repeat (100) tick();
        chk("t4_busy", int'(busy), 1);
        chk("t4_running", int'(k >= 90), 1);
        chk("t4_pass", pass_cnt, k / 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_tile_stream_source.md
Name: param_tile_stream_source

Overview:
- Streams a stored parameter tensor (bias/weight) from a fixed-latency ROM as parallel beats on a valid/ready interface.
- Replaces free-running sources that hold valid permanently high and advance on ready alone. It provides:
  - true backpressure-safe handshaking;
  - prefetch credits that cover the memory latency;
  - 2-D tiling;
  - a programmable repeat count per start.
- Sits between the generated parameter ROMs and the linear/dense compute blocks.

Parameters:
- DATA_WIDTH, 16, bits per element.
- TENSOR_SIZE_DIM_0, 32, tensor columns.
- TENSOR_SIZE_DIM_1, 4, tensor rows.
- PARALLELISM_DIM_0, 4, elements per beat along dim 0.
- PARALLELISM_DIM_1, 1, elements per beat along dim 1.
- MEM_LATENCY, 2, cycles from mem_ce/mem_addr to valid mem_q; must be ≥1.
- FIFO_DEPTH, MEM_LATENCY+2, output buffer entries.
- REPEAT_WIDTH, 8, width of the repeat input.
- Derived values:
  - BEAT = PAR0*PAR1.
  - BLK0 = T0/PAR0.
  - BLK1 = T1/PAR1.
  - OUT_DEPTH = BLK0*BLK1.
  - AWIDTH = $clog2(OUT_DEPTH)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- repeat_count  in  REPEAT_WIDTH  number of full-tensor passes, sampled on start; 0 means stream continuously until rst.
- busy  out  1  high from the cycle after an accepted start until the last beat is accepted.
- mem_addr  out  AWIDTH  ROM word address.
- mem_ce  out  1  read strobe.
- mem_q  in  DATA_WIDTH*BEAT  ROM word; element j occupies bits [DATA_WIDTH*j +: DATA_WIDTH].
- data_out  out  [DATA_WIDTH-1:0] x BEAT (unpacked)  beat elements.
- data_out_valid  out  1  beat valid.
- data_out_ready  in  1  consumer ready.
- data_out_last_row  out  1  beat is the last dim-0 block of its row.
- data_out_last  out  1  beat is the final beat of a tensor pass.
- pass_done  out  1  one-cycle pulse when a last-flagged beat is accepted.

Behaviour:
- Reset values: busy=0, mem_ce=0, mem_addr=0, data_out_valid=0, pass_done=0, FIFO empty, in-flight count=0, all counters=0, state IDLE.
- Reset mid-run:
  - Aborts immediately with no further beats.
  - ROM responses still in flight are discarded via the cleared tag pipeline.
- Address order is row-major: addr = b1*BLK0 + b0, with b0 fastest. It wraps to 0 after OUT_DEPTH-1.
- ROM contract:
  - The ROM read pipeline is enable-independent; the ROM wrapper is instantiated with ce tied high.
  - mem_q is valid exactly MEM_LATENCY cycles after each mem_ce.
  - A MEM_LATENCY-deep shift register of {valid, last_row, last} tags travels alongside the data.
  - A tag arriving at the end of the shift register writes mem_q and its flags into the FIFO.
- Credit rule:
  - mem_ce is asserted only when (fifo_count + inflight) < FIFO_DEPTH and reads remain to be issued.
  - The FIFO can never overflow.
  - Sustained throughput is 1 beat/cycle while data_out_ready=1.
- FIFO behaviour:
  - data_out and flags come from the FIFO head; data_out_valid = !fifo_empty.
  - A beat is transferred when valid&&ready.
  - Head data is held stable while valid&&!ready.
  - A simultaneous FIFO write and read is permitted in any state, including full-with-pop.
- States:
  - IDLE: busy=0. On start, load reps=repeat_count, clear the address counters, go to ISSUE.
  - ISSUE: issue reads under the credit rule. When the address wraps, decrement reps unless repeat_count was 0. When the final read of the final pass is issued, go to DRAIN.
  - DRAIN: no reads issued. When inflight==0, the FIFO is empty and no transfer is pending, go to IDLE; busy falls in the same cycle as the last transfer.
- repeat_count=0 means ISSUE never exits; only rst ends the stream.
- pass_done pulses on every accepted beat with data_out_last=1, including in continuous mode.
- Latency: the first data_out_valid rises MEM_LATENCY+2 cycles after the start pulse (1 cycle to enter ISSUE, 1 for the FIFO register).
- A start coinciding with rst is ignored.

Test Plan:
- Setup for all scenarios:
  - T0=8, T1=2, PAR0=2, PAR1=1, so BLK0=4 and OUT_DEPTH=8.
  - MEM_LATENCY=2.
  - ROM word i holds elements {2i, 2i+1}.
- Single pass, ready always 1, start with repeat_count=1:
  - data_out sequence {0,1},{2,3}…{14,15} on 8 consecutive cycles.
  - First valid 4 cycles after start.
  - last_row on beats 3 and 7; last and pass_done on beat 7.
  - busy low the same cycle as beat 7.
- Backpressure, repeat_count=1, ready toggling 1,0,0,1 repeating:
  - Same 8 beats, in order, with no loss or duplication.
  - Head stable while stalled.
  - mem_ce never asserted when fifo_count+inflight==FIFO_DEPTH (assertion).
- Repeat count 3:
  - 24 beats; the address wraps 7→0 twice.
  - Three pass_done pulses; busy drops after the 24th beat.
- Continuous mode, repeat_count=0, ready=1 for 100 cycles:
  - Stream never stops.
  - pass_done every 8 beats; busy stays 1.
- Start ignored while busy: a start pulse mid-run with repeat_count=5 is ignored, and the original run completes with 8 beats.
- Reset mid-run: rst asserted after beat 3 with reads in flight.
  - Next cycle data_out_valid=0, busy=0, mem_ce=0.
  - A fresh start then produces beats from {0,1}.
